// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Groups the two requester handshakes (instruction fetch and load/store) and
// the memory control outputs of the arbiter into one bundle.
//
//   Fetch side      : if_req, if_addr          -> arbiter
//                     if_gnt, if_done, if_rdata <- arbiter
//   Load/store side : d_req, d_we, d_addr, d_wdata -> arbiter
//                     d_gnt, d_done, d_rdata        <- arbiter
//   Memory control  : mem_enable, mem_write_enable, mem_address <- arbiter
//
// The bidirectional memory data bus is not part of this bundle; it stays a
// plain inout wire on the arbiter so the tristate resolves directly on the
// net shared with the memory.
//
// Modports:
//   slave  - the arbiter
//   master - whoever drives the requests and watches the memory controls
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_enable;
    logic              mem_write_enable;
    logic [ADDR_W-1:0] mem_address;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_done, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_done, d_rdata,
        output mem_enable, mem_write_enable, mem_address
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_done, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_done, d_rdata,
        input  mem_enable, mem_write_enable, mem_address
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-ported memory between an instruction-fetch requester and
// a load/store requester. Each access takes three cycles:
// IDLE (arbitrate) -> ACCESS (address/write phase) -> COMPLETE (read capture),
// with the winner's done pulse in the following IDLE cycle. When both ports
// want the memory in the same IDLE cycle, the port not granted last wins.
//
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous, active-high
//   bus       - requester handshakes and memory controls (slave modport)
//   mem_data  - bidirectional memory data bus; driven only during the
//               ACCESS cycle of a store, high-Z otherwise
//   busy      - high whenever the arbiter is not in IDLE
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    mem_arbiter_if.slave      bus,
    inout  wire  [DATA_W-1:0] mem_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        COMPLETE
    } state_t;

    state_t            state_q;
    logic              lastGrantData_q;
    logic              winnerData_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              drive_q;
    logic              ifGnt_q;
    logic              dGnt_q;
    logic              ifDone_q;
    logic              dDone_q;
    logic              memEn_q;
    logic              memWe_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic [DATA_W-1:0] ifRdata_q;
    logic [DATA_W-1:0] dRdata_q;
    logic              busy_q;

    logic              ifEligible;
    logic              dEligible;
    logic              grantData_d;

    // A request still held during its own done cycle is the tail of the
    // access just finished, so it must not be granted again that cycle.
    // On a tie the port that did not win last time gets the memory.
    always_comb begin
        ifEligible  = bus.if_req && !ifDone_q;
        dEligible   = bus.d_req && !dDone_q;
        grantData_d = dEligible;
        if (ifEligible && dEligible) begin
            grantData_d = !lastGrantData_q;
        end
    end

    // Single-process FSM: every output is a register so the memory controls
    // and handshake pulses are glitch-free. The memory address doubles as the
    // latched request address and returns to zero in IDLE. Read data is taken
    // off the bus at the end of COMPLETE, after the memory has had both the
    // ACCESS and COMPLETE cycles to drive it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            lastGrantData_q <= 1'b0;
            winnerData_q    <= 1'b0;
            we_q            <= 1'b0;
            wdata_q         <= '0;
            drive_q         <= 1'b0;
            ifGnt_q         <= 1'b0;
            dGnt_q          <= 1'b0;
            ifDone_q        <= 1'b0;
            dDone_q         <= 1'b0;
            memEn_q         <= 1'b0;
            memWe_q         <= 1'b0;
            memAddr_q       <= '0;
            ifRdata_q       <= '0;
            dRdata_q        <= '0;
            busy_q          <= 1'b0;
        end else begin
            ifGnt_q  <= 1'b0;
            dGnt_q   <= 1'b0;
            ifDone_q <= 1'b0;
            dDone_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ifEligible || dEligible) begin
                        state_q         <= ACCESS;
                        busy_q          <= 1'b1;
                        memEn_q         <= 1'b1;
                        winnerData_q    <= grantData_d;
                        lastGrantData_q <= grantData_d;
                        if (grantData_d) begin
                            dGnt_q    <= 1'b1;
                            memAddr_q <= bus.d_addr;
                            we_q      <= bus.d_we;
                            memWe_q   <= bus.d_we;
                            drive_q   <= bus.d_we;
                            wdata_q   <= bus.d_wdata;
                        end else begin
                            ifGnt_q   <= 1'b1;
                            memAddr_q <= bus.if_addr;
                            we_q      <= 1'b0;
                            memWe_q   <= 1'b0;
                            drive_q   <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    state_q <= COMPLETE;
                    memEn_q <= !we_q;
                    memWe_q <= 1'b0;
                    drive_q <= 1'b0;
                end
                COMPLETE: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    memEn_q   <= 1'b0;
                    memAddr_q <= '0;
                    if (winnerData_q) begin
                        dDone_q <= 1'b1;
                        if (!we_q) begin
                            dRdata_q <= mem_data;
                        end
                    end else begin
                        ifDone_q  <= 1'b1;
                        ifRdata_q <= mem_data;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_data = drive_q ? wdata_q : {DATA_W{1'bz}};

    assign bus.if_gnt           = ifGnt_q;
    assign bus.if_done          = ifDone_q;
    assign bus.if_rdata         = ifRdata_q;
    assign bus.d_gnt            = dGnt_q;
    assign bus.d_done           = dDone_q;
    assign bus.d_rdata          = dRdata_q;
    assign bus.mem_enable       = memEn_q;
    assign bus.mem_write_enable = memWe_q;
    assign bus.mem_address      = memAddr_q;
    assign busy                 = busy_q;

endmodule
